writeback_stage: RTL and testbench

Fifth pipeline stage of the RV32I core, directly downstream of the memory stage. It consumes the memory stage's registered outputs and the data-memory Wishbone response (ack/read data). It formats load data (byte/halfword select, sign/zero extension) and drives the base-register write port. It stalls the pipeline while a load's ack is outstanding and counts retired instructions.

---
 rtl/writeback_stage.sv | 161 ++++++++++++++++
 tb/tb_writeback_stage.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/writeback_stage.sv
// Writeback stage of the RV32I pipeline: formats load data, drives the
// base-register write port, stalls while a load's ack is outstanding and
// counts retired instructions.

`ifndef OPCODE_WIDTH
`define OPCODE_WIDTH 11
`endif
`ifndef LOAD
`define LOAD 0
`endif
`ifndef STORE
`define STORE 1
`endif

module writeback_stage #(
    parameter int OPCODE_W  = `OPCODE_WIDTH,
    parameter int INSTRET_W = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [2:0]           memory_funct3,
    input  logic [OPCODE_W-1:0]  memory_opcode_type,
    input  logic                 memory_rd_wr_en,
    input  logic [4:0]           memory_rd,
    input  logic [31:0]          memory_rd_wr_data,
    input  logic [1:0]           memory_addr_lsb,
    input  logic                 main_memory_wb_ack,
    input  logic [31:0]          main_memory_wb_rd_data,
    input  logic                 clk_en,
    input  logic                 stall,
    input  logic                 flush,
    output logic                 rf_wr_en,
    output logic [4:0]           rf_wr_addr,
    output logic [31:0]          rf_wr_data,
    output logic                 retire,
    output logic [INSTRET_W-1:0] instret,
    output logic                 next_stall
);

    typedef enum logic [1:0] {RUN, WAIT_ACK, DRAIN} state_t;

    state_t                 state, state_nx;
    logic                   buf_valid;
    logic [31:0]            buf_data;
    logic [INSTRET_W-1:0]   instret_q;

    logic                   valid, is_load;
    logic                   complete, use_buf, ack_used, kill_buf, stall_req;
    logic [31:0]            load_word;
    logic                   unused_opcode;

    assign valid         = clk_en & ~flush;
    assign is_load       = memory_opcode_type[`LOAD];
    assign unused_opcode = ^memory_opcode_type;

    function automatic logic [31:0] load_fmt(input logic [2:0]  f3,
                                             input logic [1:0]  lsb,
                                             input logic [31:0] d);
        logic [7:0]  b;
        logic [15:0] h;
        case (lsb)
            2'd0:    b = d[7:0];
            2'd1:    b = d[15:8];
            2'd2:    b = d[23:16];
            default: b = d[31:24];
        endcase
        h = lsb[1] ? d[31:16] : d[15:0];
        case (f3)
            3'b000:  load_fmt = {{24{b[7]}}, b};
            3'b100:  load_fmt = {24'd0, b};
            3'b001:  load_fmt = {{16{h[15]}}, h};
            3'b101:  load_fmt = {16'd0, h};
            3'b010:  load_fmt = d;
            default: load_fmt = '0;
        endcase
    endfunction

    // Completion, ack ownership and next-state decision for the current instruction
    always_comb begin
        state_nx  = state;
        complete  = 1'b0;
        use_buf   = 1'b0;
        ack_used  = 1'b0;
        kill_buf  = 1'b0;
        stall_req = 1'b0;
        case (state)
            RUN: begin
                if (valid && is_load) begin
                    if (buf_valid || main_memory_wb_ack) begin
                        if (!stall) begin
                            complete = 1'b1;
                            use_buf  = buf_valid;
                            ack_used = ~buf_valid;
                        end
                    end else begin
                        stall_req = 1'b1;
                        if (!stall) state_nx = WAIT_ACK;
                    end
                end else if (valid && !stall) begin
                    complete = 1'b1;
                end
            end
            WAIT_ACK: begin
                // Killed while waiting: data already here (or arriving now)
                // belongs to the dead load; otherwise drain the future ack.
                if (!valid) begin
                    ack_used = main_memory_wb_ack;
                    kill_buf = 1'b1;
                    state_nx = (main_memory_wb_ack || buf_valid) ? RUN : DRAIN;
                end else if (buf_valid || main_memory_wb_ack) begin
                    if (!stall) begin
                        complete = 1'b1;
                        use_buf  = buf_valid;
                        ack_used = ~buf_valid;
                        state_nx = RUN;
                    end
                end else begin
                    stall_req = 1'b1;
                end
            end
            DRAIN: begin
                stall_req = valid & is_load;
                if (main_memory_wb_ack) begin
                    ack_used = 1'b1;
                    state_nx = (valid && is_load) ? WAIT_ACK : RUN;
                end
                if (valid && !is_load && !stall) complete = 1'b1;
            end
            default: state_nx = RUN;
        endcase
    end

    assign load_word  = use_buf ? buf_data : main_memory_wb_rd_data;
    assign retire     = ~rst & complete;
    assign rf_wr_en   = retire & memory_rd_wr_en & (|memory_rd);
    assign rf_wr_addr = memory_rd;
    assign rf_wr_data = is_load ? load_fmt(memory_funct3, memory_addr_lsb, load_word)
                                : memory_rd_wr_data;
    assign next_stall = ~rst & stall_req;
    assign instret    = instret_q;

    // State, early-ack buffer and retired-instruction counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= RUN;
            buf_valid <= 1'b0;
            buf_data  <= '0;
            instret_q <= '0;
        end else begin
            state <= state_nx;
            if (main_memory_wb_ack && !ack_used) begin
                buf_valid <= 1'b1;
                buf_data  <= main_memory_wb_rd_data;
            end else if (use_buf || kill_buf) begin
                buf_valid <= 1'b0;
            end
            if (complete) instret_q <= instret_q + 1'b1;
        end
    end

endmodule

// File: tb/tb_writeback_stage.sv
// Bench for writeback_stage: directed steps from the test plan followed by
// random traffic, all checked against a behavioural model of the stage.

`ifndef OPCODE_WIDTH
`define OPCODE_WIDTH 11
`endif
`ifndef LOAD
`define LOAD 0
`endif
`ifndef STORE
`define STORE 1
`endif

module tb_writeback_stage;

    localparam int OW      = `OPCODE_WIDTH;
    localparam int ALU_BIT = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic [2:0]    memory_funct3;
    logic [OW-1:0] memory_opcode_type;
    logic          memory_rd_wr_en;
    logic [4:0]    memory_rd;
    logic [31:0]   memory_rd_wr_data;
    logic [1:0]    memory_addr_lsb;
    logic          main_memory_wb_ack;
    logic [31:0]   main_memory_wb_rd_data;
    logic          clk_en, stall, flush;
    logic          rf_wr_en;
    logic [4:0]    rf_wr_addr;
    logic [31:0]   rf_wr_data;
    logic          retire;
    logic [63:0]   instret;
    logic          next_stall;

    writeback_stage #(.OPCODE_W(OW), .INSTRET_W(64)) dut (
        .clk(clk), .rst(rst),
        .memory_funct3(memory_funct3), .memory_opcode_type(memory_opcode_type),
        .memory_rd_wr_en(memory_rd_wr_en), .memory_rd(memory_rd),
        .memory_rd_wr_data(memory_rd_wr_data), .memory_addr_lsb(memory_addr_lsb),
        .main_memory_wb_ack(main_memory_wb_ack),
        .main_memory_wb_rd_data(main_memory_wb_rd_data),
        .clk_en(clk_en), .stall(stall), .flush(flush),
        .rf_wr_en(rf_wr_en), .rf_wr_addr(rf_wr_addr), .rf_wr_data(rf_wr_data),
        .retire(retire), .instret(instret), .next_stall(next_stall)
    );

    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;

    // Model: words that arrived early, whether a live load is waiting, and
    // how many acks are owed to killed loads.
    logic [31:0] m_early[$];
    bit          m_waiting;
    int          m_owed;
    logic [63:0] m_count;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [1:0] lsb,
                                             input logic [31:0] d);
        longint unsigned b, h;
        b = (longint'(d) >> (8 * lsb)) & 64'hFF;
        h = (longint'(d) >> (16 * (lsb / 2))) & 64'hFFFF;
        case (f3)
            3'd0:    return (b >= 128) ? 32'(b + 64'hFFFF_FF00) : 32'(b);
            3'd4:    return 32'(b);
            3'd1:    return (h >= 32768) ? 32'(h + 64'hFFFF_0000) : 32'(h);
            3'd5:    return 32'(h);
            3'd2:    return d;
            default: return 32'd0;
        endcase
    endfunction

    task automatic set_instr(input int kind, input logic [4:0] rd, input bit we,
                             input logic [2:0] f3, input logic [1:0] lsb,
                             input logic [31:0] res);
        memory_opcode_type = '0;
        case (kind)
            1:       memory_opcode_type[`LOAD]  = 1'b1;
            2:       memory_opcode_type[`STORE] = 1'b1;
            default: memory_opcode_type[ALU_BIT] = 1'b1;
        endcase
        memory_rd = rd; memory_rd_wr_en = we; memory_funct3 = f3;
        memory_addr_lsb = lsb; memory_rd_wr_data = res;
    endtask

    task automatic model_reset();
        m_early.delete();
        m_waiting = 0;
        m_owed    = 0;
        m_count   = '0;
    endtask

    // One clock with the inputs currently driven: predict, compare, advance.
    task automatic cycle();
        bit live, ld, ack, ret, exp_stall, ack_spent;
        logic [31:0] word;
        #1;
        live = clk_en && !flush;
        ld   = memory_opcode_type[`LOAD];
        ack  = main_memory_wb_ack;
        ret = 0; exp_stall = 0; ack_spent = 0; word = 'x;
        if (m_owed > 0) begin
            exp_stall = live && ld;
            ret = live && !ld && !stall;
            if (ack) begin
                m_owed--; ack_spent = 1;
                m_waiting = live && ld;
            end
        end else if (m_waiting && !live) begin
            m_waiting = 0;
            if (ack || m_early.size() > 0) begin
                m_early.delete(); ack_spent = ack;
            end else begin
                m_owed++;
            end
        end else if (m_waiting || (live && ld)) begin
            exp_stall = (m_early.size() == 0) && !ack;
            if (!stall) begin
                if (m_early.size() > 0) begin
                    ret = 1; word = m_early.pop_front(); m_waiting = 0;
                end else if (ack) begin
                    ret = 1; word = main_memory_wb_rd_data; ack_spent = 1; m_waiting = 0;
                end else begin
                    m_waiting = 1;
                end
            end
        end else begin
            ret = live && !stall;
        end
        chk("retire", retire, ret);
        chk("rf_wr_en", rf_wr_en, ret && memory_rd_wr_en && memory_rd != 0);
        chk("next_stall", next_stall, exp_stall);
        if (ret) begin
            chk("rf_wr_addr", rf_wr_addr, memory_rd);
            chk("rf_wr_data", rf_wr_data,
                ld ? ref_load(memory_funct3, memory_addr_lsb, word) : memory_rd_wr_data);
        end
        if (ack && !ack_spent) begin
            m_early.delete();
            m_early.push_back(main_memory_wb_rd_data);
        end
        if (ret) m_count++;
        @(posedge clk);
        #1;
        chk("instret", instret, m_count);
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1;
        clk_en = 0; stall = 0; flush = 0;
        main_memory_wb_ack = 0; main_memory_wb_rd_data = '0;
        set_instr(0, 5'd0, 0, 3'd0, 2'd0, 32'd0);
        model_reset();
        repeat (2) @(negedge clk);
        chk("rst_retire", retire, 1'b0);
        chk("rst_wr_en", rf_wr_en, 1'b0);
        chk("rst_stall", next_stall, 1'b0);
        chk("rst_instret", instret, 64'd0);
        rst = 1'b0;
        @(negedge clk);

        // ADD writes its result the same cycle
        clk_en = 1;
        set_instr(0, 5'd5, 1, 3'd0, 2'd0, 32'h0000_1234);
        #1;
        chk("add_wr_en", rf_wr_en, 1'b1);
        chk("add_addr", rf_wr_addr, 5'd5);
        chk("add_data", rf_wr_data, 32'h0000_1234);
        cycle();
        chk("add_instret", instret, 64'd1);

        // LB / LBU with ack in the same cycle
        set_instr(1, 5'd6, 1, 3'b000, 2'd3, 32'd0);
        main_memory_wb_ack = 1; main_memory_wb_rd_data = 32'h80FF_7F01;
        #1;
        chk("lb_data", rf_wr_data, 32'hFFFF_FF80);
        chk("lb_stall", next_stall, 1'b0);
        cycle();
        set_instr(1, 5'd7, 1, 3'b100, 2'd1, 32'd0);
        #1;
        chk("lbu_data", rf_wr_data, 32'h0000_007F);
        cycle();

        // LH with the ack three cycles late
        set_instr(1, 5'd8, 1, 3'b001, 2'd2, 32'd0);
        main_memory_wb_ack = 0; main_memory_wb_rd_data = 32'h8001_0000;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("lh_wait_stall", next_stall, 1'b1);
            cycle();
        end
        main_memory_wb_ack = 1;
        #1;
        chk("lh_data", rf_wr_data, 32'hFFFF_8001);
        chk("lh_retire", retire, 1'b1);
        chk("lh_stall", next_stall, 1'b0);
        cycle();

        // Load to x0 retires without a write
        set_instr(1, 5'd0, 1, 3'b010, 2'd0, 32'd0);
        #1;
        chk("x0_wr_en", rf_wr_en, 1'b0);
        chk("x0_retire", retire, 1'b1);
        cycle();

        // Flushed load in WAIT_ACK, then a new LW stalls through the discarded ack
        set_instr(1, 5'd9, 1, 3'b010, 2'd0, 32'd0);
        main_memory_wb_ack = 0;
        cycle();
        flush = 1;
        cycle();
        flush = 0;
        set_instr(1, 5'd10, 1, 3'b010, 2'd0, 32'd0);
        #1;
        chk("drain_stall", next_stall, 1'b1);
        cycle();
        main_memory_wb_ack = 1; main_memory_wb_rd_data = 32'hAAAA_AAAA;
        #1;
        chk("drain_ack_retire", retire, 1'b0);
        chk("drain_ack_stall", next_stall, 1'b1);
        cycle();
        main_memory_wb_rd_data = 32'h1234_5678;
        #1;
        chk("lw2_data", rf_wr_data, 32'h1234_5678);
        chk("lw2_wr_en", rf_wr_en, 1'b1);
        cycle();

        // Ack arriving during stall is buffered for the next load
        clk_en = 0; stall = 1;
        main_memory_wb_ack = 1; main_memory_wb_rd_data = 32'hDEAD_BEEF;
        cycle();
        stall = 0; main_memory_wb_ack = 0; main_memory_wb_rd_data = '0;
        clk_en = 1;
        set_instr(1, 5'd11, 1, 3'b010, 2'd0, 32'd0);
        #1;
        chk("early_data", rf_wr_data, 32'hDEAD_BEEF);
        chk("early_retire", retire, 1'b1);
        chk("early_stall", next_stall, 1'b0);
        cycle();

        // Reset in the middle of WAIT_ACK
        cycle();
        rst = 1;
        #1;
        chk("mid_rst_wr_en", rf_wr_en, 1'b0);
        chk("mid_rst_stall", next_stall, 1'b0);
        chk("mid_rst_instret", instret, 64'd0);
        model_reset();
        @(negedge clk);
        rst = 0; clk_en = 0;
        main_memory_wb_ack = 1; main_memory_wb_rd_data = 32'h0BAD_F00D;
        cycle();
        main_memory_wb_ack = 0; clk_en = 1;
        cycle();

        // Random traffic
        for (int n = 0; n < 600; n++) begin
            set_instr($urandom_range(0, 2), 5'($urandom_range(0, 31)), 1'($urandom),
                      3'($urandom), 2'($urandom), $urandom);
            clk_en = ($urandom_range(0, 99) < 85);
            flush  = ($urandom_range(0, 99) < 10);
            stall  = ($urandom_range(0, 99) < 20);
            main_memory_wb_ack     = ($urandom_range(0, 99) < 35);
            main_memory_wb_rd_data = $urandom;
            cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
